multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Parametrised successor to the single-cycle datapath ALU for the multi-cycle MIPS32 core.
- Adds registered results and signed SLT/unsigned SLTU.
- Adds iterative multiply/divide into HI/LO, MFHI/MFLO, and a start/busy/done handshake so the control FSM can stall on long ops.
- Sits between the A/B operand registers and ALUOut; the control unit drives start and waits for done.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, ≥8.
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset (0 = reset, sampled on clk rising edge)
- start  input  1  request; sampled only in IDLE
- alu_op  input  4  operation code (see Behaviour)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- result  output  WIDTH  registered result
- zero  output  1  1 when result == 0 (any op)
- busy  output  1  1 in any non-IDLE state
- done  output  1  one-cycle pulse, result/hi/lo valid
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- div_by_zero  output  1  sticky until next accepted start; set by DIV/DIVU with b==0

Behaviour:
- Reset (rst==0 at edge): state=IDLE; result, hi, lo = 0; zero=1; busy=0; done=0; div_by_zero=0. Aborts any op in progress; no partial HI/LO write.
- Op codes:
  - 0 ADD; 1 SUB (both wrap modulo 2^WIDTH, no overflow flag)
  - 2 OR; 3 AND; 4 NOR; 5 XOR
  - 6 SLT: signed compare, result 1/0
  - 7 SLL: a << b[SHW-1:0]
  - 8 SRL: logical a >> b[SHW-1:0]
  - 9 MULTU; 10 MULT (signed)
  - 11 DIVU; 12 DIV (signed)
  - 13 MFHI: result=hi; 14 MFLO: result=lo
  - 15 SLTU: unsigned compare
- States: IDLE, ITER, FIX, DONE.
- IDLE, start==1 at edge N:
  - a, b, alu_op are latched.
  - Short ops (0–8, 13–15): result is written at edge N and state goes to DONE. done=1 in cycle N+1, then IDLE at edge N+1. Latency 1.
  - Long ops (9–12): go to ITER with count=0. MULT/DIV operate on magnitudes; operand signs are latched.
- ITER:
  - One radix-2 step per cycle (shift-add multiply, restoring divide); count increments.
  - After WIDTH steps, go to FIX.
- FIX (one cycle):
  - Applies sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes hi/lo. result=lo. Goes to DONE.
  - done asserts WIDTH+2 cycles after the start edge: 34 for WIDTH=32.
- MULT/MULTU: {hi,lo} = full 2*WIDTH product.
- DIV/DIVU: lo=quotient, hi=remainder.
- Divide by zero: still runs full latency; hi=a, lo=all ones, div_by_zero=1.
- Signed DIV of MIN by -1: lo=MIN, hi=0, no flag.
- hi/lo change only in FIX or on reset. Short ops never alter hi/lo.
- start while busy: ignored, not queued. Operand/op changes during busy have no effect.
- start held high continuously: a new op is accepted in each IDLE cycle, giving back-to-back short ops every 2 cycles.
- zero is derived combinationally from the registered result.
- div_by_zero clears on the next accepted start.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-ITER of MULT -> busy=0, done=0, hi=lo=result=0, zero=1; next MFLO returns 0.
- Short ops, WIDTH=32:
  - SUB a=5, b=5 -> done one cycle later, result=0, zero=1.
  - SLT a=0xFFFFFFFF, b=1 -> result=1.
  - SLTU same operands -> result=0.
  - SLL a=1, b=0x21 -> result=2 (shift uses b[4:0]).
- MULT a=-3 (0xFFFFFFFD), b=7 -> done exactly 34 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide:
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=10, b=0 -> div_by_zero=1, hi=10, lo=0xFFFFFFFF after 34 cycles; next ADD start clears flag and leaves hi/lo unchanged.
- start pulsed during ITER with ADD 1+1 -> ignored; long op completes with correct hi/lo; single done pulse; result=lo.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle MIPS32 ALU: single-cycle short ops with a registered result, plus
// radix-2 iterative multiply/divide into HI/LO behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int DW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_MFHI  = 4'd13;
  localparam logic [3:0] OP_MFLO  = 4'd14;
  localparam logic [3:0] OP_SLTU  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [DW-1:0]    work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [3:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dz_q, dz_d;

  logic             signed_op_s;
  logic             sa_s, sb_s;
  logic [DW-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [DW-1:0] cneg_dw(input logic [DW-1:0] v, input logic neg);
    return neg ? (~v + DW'(1)) : v;
  endfunction

  function automatic logic is_long(input logic [3:0] op);
    return (op >= OP_MULTU) && (op <= OP_DIV);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

  function automatic logic [WIDTH-1:0] short_calc(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic [WIDTH-1:0] h,
                                                  input logic [WIDTH-1:0] l);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLL:  r = x << y[SHW-1:0];
      OP_SRL:  r = x >> y[SHW-1:0];
      OP_MFHI: r = h;
      OP_MFLO: r = l;
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Shift-add step: upper half accumulates the multiplicand, then the pair shifts right.
  function automatic logic [DW-1:0] mul_step(input logic [DW-1:0] w, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, w[DW-1:WIDTH]} + (w[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, w[WIDTH-1:1]};
  endfunction

  // Restoring step on {remainder, quotient}: shift left, keep the trial difference if non-negative.
  function automatic logic [DW-1:0] div_step(input logic [DW-1:0] w, input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh, df;
    sh = {w[DW-1:WIDTH], w[WIDTH-1]};
    df = sh - {1'b0, d};
    return df[WIDTH] ? {sh[WIDTH-1:0], w[WIDTH-2:0], 1'b0}
                     : {df[WIDTH-1:0], w[WIDTH-2:0], 1'b1};
  endfunction

  assign signed_op_s = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign sa_s        = signed_op_s & a[WIDTH-1];
  assign sb_s        = signed_op_s & b[WIDTH-1];
  assign prod_s      = cneg_dw(work_q, neg_a_q ^ neg_b_q);
  assign quo_s       = cneg(work_q[WIDTH-1:0], neg_a_q ^ neg_b_q);
  assign rem_s       = cneg(work_q[DW-1:WIDTH], neg_a_q);

  // Next-state and datapath decode
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          op_d = alu_op;
          a_d  = a;
          if (is_long(alu_op)) begin
            state_d = S_ITER;
            count_d = {SHW{1'b0}};
            neg_a_d = sa_s;
            neg_b_d = sb_s;
            if (is_mul(alu_op)) begin
              opnd_d = cneg(a, sa_s);
              work_d = {{WIDTH{1'b0}}, cneg(b, sb_s)};
            end else begin
              opnd_d = cneg(b, sb_s);
              work_d = {{WIDTH{1'b0}}, cneg(a, sa_s)};
            end
          end else begin
            state_d  = S_DONE;
            result_d = short_calc(alu_op, a, b, hi_q, lo_q);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        count_d = count_q + SHW'(1);
        work_d  = is_mul(op_q) ? mul_step(work_q, opnd_q) : div_step(work_q, opnd_q);
        if (count_q == SHW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_mul(op_q)) begin
          hi_d     = prod_s[DW-1:WIDTH];
          lo_d     = prod_s[WIDTH-1:0];
          result_d = prod_s[WIDTH-1:0];
        end else if (opnd_q == {WIDTH{1'b0}}) begin
          hi_d     = a_q;
          lo_d     = {WIDTH{1'b1}};
          result_d = {WIDTH{1'b1}};
          dz_d     = 1'b1;
        end else begin
          hi_d     = rem_s;
          lo_d     = quo_s;
          result_d = quo_s;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= {SHW{1'b0}};
      work_q   <= {DW{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      op_q     <= 4'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
    end
  end

  assign result      = result_q;
  assign zero        = (result_q == {WIDTH{1'b0}});
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against a plain-arithmetic
// reference model (64-bit products, native / and % with the MIPS corner cases).
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_op;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi, m_lo;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .result(result), .zero(zero), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_short(input logic [3:0] op, input logic [31:0] x, y, h, l);
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x | y;
      4'd3:  return x & y;
      4'd4:  return ~(x | y);
      4'd5:  return x ^ y;
      4'd6:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd7:  return x << y[4:0];
      4'd8:  return x >> y[4:0];
      4'd13: return h;
      4'd14: return l;
      4'd15: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_long(input logic [3:0] op, input logic [31:0] x, y,
                          output logic [31:0] h, l, output logic dzf);
    longint          p;
    longint unsigned pu;
    dzf = 1'b0;
    h = 32'd0;
    l = 32'd0;
    if (op == 4'd9) begin
      pu = {32'd0, x} * {32'd0, y};
      {h, l} = pu;
    end else if (op == 4'd10) begin
      p = longint'($signed(x)) * longint'($signed(y));
      {h, l} = p;
    end else if (y == 32'd0) begin
      h = x; l = 32'hFFFF_FFFF; dzf = 1'b1;
    end else if (op == 4'd11) begin
      l = x / y; h = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      l = 32'h8000_0000; h = 32'd0;
    end else begin
      l = $signed(x) / $signed(y); h = $signed(x) % $signed(y);
    end
  endtask

  // Issue one op from a negedge with the DUT idle; returns cycles to done and the
  // outputs seen in the done cycle, then steps one more cycle so the DUT is idle again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, y, output int lat,
                        output logic [31:0] r, h, l, output logic z, dzf, d_after);
    alu_op = op; a = x; b = y; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    r = result; h = hi; l = lo; z = zero; dzf = div_by_zero;
    @(posedge clk); @(negedge clk);
    d_after = done;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] r, h, l; logic z, dzf, da;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, zero, div_by_zero} !== 4'b0010) begin errors++;
      $display("FAIL reset_flags got=%b exp=0010", {busy, done, zero, div_by_zero}); end
    checks++; if ({result, hi, lo} !== 96'd0) begin errors++;
      $display("FAIL reset_regs got=%h exp=0", {result, hi, lo}); end
    rst = 1'b1;
    run_op(4'd9, 32'h0001_2345, 32'h0006_7890, lat, r, h, l, z, dzf, da);
    alu_op = 4'd10; a = 32'h7654_3210; b = 32'h89AB_CDEF; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({busy, done, zero, div_by_zero} !== 4'b0010) begin errors++;
      $display("FAIL midop_reset_flags got=%b exp=0010", {busy, done, zero, div_by_zero}); end
    checks++; if ({result, hi, lo} !== 96'd0) begin errors++;
      $display("FAIL midop_reset_regs got=%h exp=0", {result, hi, lo}); end
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, lat, r, h, l, z, dzf, da);
    checks++; if ({r, z} !== {32'd0, 1'b1}) begin errors++;
      $display("FAIL mflo_after_reset got=%h/%b exp=0/1", r, z); end
  endtask

  task automatic test_long();
    logic [3:0] t_op[20]; logic [31:0] t_a[20], t_b[20];
    int lat; logic [31:0] r, h, l, eh, el; logic z, dzf, da, edz;
    t_op[0] = 4'd10; t_a[0] = 32'hFFFF_FFFD; t_b[0] = 32'd7;
    t_op[1] = 4'd9;  t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'hFFFF_FFFF;
    t_op[2] = 4'd12; t_a[2] = 32'hFFFF_FFF9; t_b[2] = 32'd2;
    t_op[3] = 4'd12; t_a[3] = 32'h8000_0000; t_b[3] = 32'hFFFF_FFFF;
    t_op[4] = 4'd12; t_a[4] = 32'hFFFF_FFF9; t_b[4] = 32'd0;
    t_op[5] = 4'd11; t_a[5] = 32'hDEAD_BEEF; t_b[5] = 32'h0000_1234;
    for (int i = 6; i < 20; i++) begin
      t_op[i] = 4'(9 + $urandom_range(0, 3));
      t_a[i]  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      t_b[i]  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
    end
    for (int i = 0; i < 20; i++) begin
      ref_long(t_op[i], t_a[i], t_b[i], eh, el, edz);
      run_op(t_op[i], t_a[i], t_b[i], lat, r, h, l, z, dzf, da);
      checks++; if (lat !== 34) begin errors++;
        $display("FAIL long_latency op=%0d got=%0d exp=34", t_op[i], lat); end
      checks++; if ({h, l} !== {eh, el}) begin errors++;
        $display("FAIL long_hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h", t_op[i], t_a[i], t_b[i], h, l, eh, el); end
      checks++; if ({r, z, dzf, da} !== {el, (el == 32'd0), edz, 1'b0}) begin errors++;
        $display("FAIL long_result op=%0d got=%h/%b/%b/%b exp=%h/%b/%b/0", t_op[i], r, z, dzf, da, el, (el == 32'd0), edz); end
      m_hi = eh; m_lo = el;
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] r, h, l; logic z, dzf, da;
    run_op(4'd11, 32'd10, 32'd0, lat, r, h, l, z, dzf, da);
    checks++; if ({lat, dzf, h, l} !== {32'd34, 1'b1, 32'd10, 32'hFFFF_FFFF}) begin errors++;
      $display("FAIL divu_zero got lat=%0d dz=%b hi=%h lo=%h exp 34/1/0000000a/ffffffff", lat, dzf, h, l); end
    run_op(4'd0, 32'd3, 32'd4, lat, r, h, l, z, dzf, da);
    checks++; if ({dzf, r, h, l} !== {1'b0, 32'd7, 32'd10, 32'hFFFF_FFFF}) begin errors++;
      $display("FAIL dz_clear got dz=%b r=%h hi=%h lo=%h exp 0/7/a/ffffffff", dzf, r, h, l); end
    m_hi = 32'd10; m_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_short();
    logic [3:0] ops[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13, 4'd14, 4'd15};
    logic [3:0] t_op[40]; logic [31:0] t_a[40], t_b[40];
    int lat; logic [31:0] r, h, l, e; logic z, dzf, da;
    t_op[0] = 4'd1;  t_a[0] = 32'd5;         t_b[0] = 32'd5;
    t_op[1] = 4'd6;  t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'd1;
    t_op[2] = 4'd15; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'd1;
    t_op[3] = 4'd7;  t_a[3] = 32'd1;         t_b[3] = 32'h21;
    for (int i = 4; i < 40; i++) begin
      t_op[i] = ops[$urandom_range(0, 11)];
      t_a[i]  = $urandom;
      t_b[i]  = ($urandom_range(0, 3) == 0) ? t_a[i] : $urandom;
    end
    for (int i = 0; i < 40; i++) begin
      e = ref_short(t_op[i], t_a[i], t_b[i], m_hi, m_lo);
      run_op(t_op[i], t_a[i], t_b[i], lat, r, h, l, z, dzf, da);
      checks++; if ({lat, da} !== {32'd1, 1'b0}) begin errors++;
        $display("FAIL short_timing op=%0d got lat=%0d done_after=%b exp 1/0", t_op[i], lat, da); end
      checks++; if ({r, z} !== {e, (e == 32'd0)}) begin errors++;
        $display("FAIL short_result op=%0d a=%h b=%h got=%h/%b exp=%h/%b", t_op[i], t_a[i], t_b[i], r, z, e, (e == 32'd0)); end
      checks++; if ({h, l} !== {m_hi, m_lo}) begin errors++;
        $display("FAIL short_hilo op=%0d got=%h_%h exp=%h_%h", t_op[i], h, l, m_hi, m_lo); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] x, y, eh, el, r, h, l; logic edz;
    int pulses = 0, first = 0;
    x = $urandom; y = $urandom;
    ref_long(4'd10, x, y, eh, el, edz);
    alu_op = 4'd10; a = x; b = y; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first == 0) begin first = c; r = result; h = hi; l = lo; end
      end
      if (c == 5) begin start = 1'b1; alu_op = 4'd0; a = 32'd1; b = 32'd1; end
      else start = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    checks++; if ({pulses, first} !== {32'd1, 32'd34}) begin errors++;
      $display("FAIL ignore_start got pulses=%0d at=%0d exp 1/34", pulses, first); end
    checks++; if ({r, h, l} !== {el, eh, el}) begin errors++;
      $display("FAIL ignore_start_hilo got=%h %h_%h exp=%h %h_%h", r, h, l, el, eh, el); end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    alu_op = 4'd0; a = x; b = y; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      checks++; if ({done, busy, result} !== {1'b1, 1'b1, x + y}) begin errors++;
        $display("FAIL b2b_done k=%0d got=%b%b/%h exp=11/%h", k, done, busy, result, x + y); end
      a = $urandom; b = $urandom;
      @(posedge clk); @(negedge clk);
      checks++; if ({done, busy, result} !== {1'b0, 1'b0, x + y}) begin errors++;
        $display("FAIL b2b_idle k=%0d got=%b%b/%h exp=00/%h", k, done, busy, result, x + y); end
      x = $urandom; y = $urandom; a = x; b = y;
    end
    start = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; alu_op = 4'd0; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    test_reset();
    test_long();
    test_div_zero();
    test_short();
    test_ignore_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
